fifo_read_streamer: RTL
=======================

Name: fifo_read_streamer

Overview:
- Read-side master for the 18-bit, 1024-deep, non-FWFT dual-clock word FIFO in the DM interface datapath. Runs entirely in the read clock domain.
- Pops words with RE/EMPTY/Q, absorbs the fixed RE-to-Q latency, and presents a valid/ready stream to the downstream actuator-frame consumer.
- Tags every FRAME_LEN-th word with LAST.
- Credit-based issue, so no word is ever dropped when the downstream stalls.

Parameters:
- WIDTH, 18: data word width; matches FIFO Q.
- RD_LATENCY, 1: cycles from FIFO_RE high to FIFO_Q valid. Legal values 1..3.
- BUF_DEPTH, 4: output buffer entries. Power of 2, must be >= RD_LATENCY+1.
- FRAME_LEN, 1024: words per frame. Range 1..65535.

Ports:
- RCLOCK  in  1  read-domain clock; all logic on the rising edge.
- RRESET_N  in  1  reset, synchronous, active-low.
- ENABLE  in  1  permits new FIFO reads when high.
- FIFO_EMPTY  in  1  FIFO EMPTY flag, registered in the RCLOCK domain.
- FIFO_RE  out  1  FIFO read enable, active-high.
- FIFO_Q  in  WIDTH  FIFO read data.
- M_DATA  out  WIDTH  stream data.
- M_VALID  out  1  stream valid.
- M_READY  in  1  stream ready.
- M_LAST  out  1  high with the final word of each frame.
- WORD_CNT  out  16  index of the current M_DATA word within its frame.
- BUSY  out  1  high while any word is in flight or buffered.

Behaviour:
- Reset (RRESET_N=0 sampled at an RCLOCK edge): all outputs 0. Buffer pointers, occupancy, in-flight shift register and frame counter cleared.
  - Reset mid-operation discards in-flight and buffered words. The FIFO is reset in the same cycle by system convention.
- Issue rule: FIFO_RE = ENABLE & ~FIFO_EMPTY & (occ + inflight + 1 <= BUF_DEPTH).
  - Output is combinational from registered state plus inputs, so RE can be asserted back-to-back.
  - FIFO_EMPTY already reflects the read issued in the previous cycle, so a 1-word FIFO yields exactly one RE.
- In-flight tracking: a RD_LATENCY-stage valid shift register, fed by FIFO_RE. inflight = popcount of the stages. At the tail stage, FIFO_Q is written into the buffer at wptr.
- Buffer: circular, BUF_DEPTH entries, pointers of clog2(BUF_DEPTH)+1 bits.
  - occ = wptr - rptr.
  - A write and a read in the same cycle leave occ unchanged.
  - Overflow cannot occur by construction. Assert in simulation.
- Output:
  - M_VALID = (occ != 0).
  - M_DATA = buf[rptr], stable while M_VALID & ~M_READY.
  - A transfer is M_VALID & M_READY; rptr increments.
  - A write landing on an empty buffer becomes visible on M_VALID the next cycle (registered).
- Latency, empty buffer, M_READY=1: FIFO_RE at cycle t → M_VALID at t+RD_LATENCY+1.
- Sustained throughput: 1 word/cycle while the FIFO is non-empty and M_READY=1.
- Frame counter (WORD_CNT):
  - Increments on each transfer.
  - M_LAST = M_VALID & (WORD_CNT == FRAME_LEN-1).
  - A transfer with M_LAST set wraps WORD_CNT to 0.
  - FRAME_LEN=1: M_LAST is high on every valid word.
- ENABLE low: no new RE. In-flight words still land and the buffer still drains. WORD_CNT is held, not reset.
- M_READY low: at most BUF_DEPTH-occ-inflight further reads are issued, then FIFO_RE stays 0 until space frees. Data order is preserved.
- BUSY = (occ != 0) | (inflight != 0).

Decomposition:
- Shared package dm_fifo_pkg holds:
  - DM_WORD_W = 18
  - DM_FIFO_DEPTH = 1024
  - DM_FRAME_LEN default
  - typedef dm_word_t (logic [DM_WORD_W-1:0])
- One sub-module: fifo_read_skid_buf, the circular buffer with occ/full/empty outputs.
  - Top level keeps the issue logic, latency pipe and frame counter.

Test Plan:
- Reset and idle: hold RRESET_N=0 for 3 cycles, FIFO_EMPTY=0 → all outputs 0 throughout. After release with ENABLE=1, first FIFO_RE on the first cycle.
- Streaming: FIFO model with 8 words 0x00001..0x00008, RD_LATENCY=1, M_READY=1 → 8 consecutive RE cycles. M_VALID from RE+2. Data in order, 1 word/cycle. BUSY falls 1 cycle after the last transfer.
- Backpressure: M_READY=0 with 10 words queued, BUF_DEPTH=4 → exactly 4 REs, then FIFO_RE=0. M_DATA holds 0x00001. Release → remaining 6 words follow in order, none lost or duplicated.
- Framing: FRAME_LEN=4, 9 words → M_LAST on words 4 and 8. WORD_CNT sequence 0,1,2,3,0,1,2,3,0.
- Boundary: FIFO holds 1 word, EMPTY rises the cycle after RE → exactly one RE and one output word. Random M_READY with RD_LATENCY=3 → scoreboard matches, occupancy never exceeds 4.
- Mid-operation: ENABLE drops with 2 words in flight → both still delivered, no further RE. Reset asserted with occ=3 → M_VALID=0 next cycle and WORD_CNT=0.

Source files
------------

// File: rtl/dm_fifo_pkg.sv
// Shared constants and types for the DM interface word FIFO datapath.
package dm_fifo_pkg;

   localparam int DM_WORD_W     = 18;
   localparam int DM_FIFO_DEPTH = 1024;
   localparam int DM_FRAME_LEN  = 1024;

   typedef logic [DM_WORD_W-1:0] dm_word_t;

endpackage

// File: rtl/fifo_read_skid_buf.sv
// Circular output buffer for the FIFO read streamer. Pointers carry one
// extra wrap bit so that full and empty are told apart by occupancy.
module fifo_read_skid_buf
   import dm_fifo_pkg::*;
#(
   parameter int  WIDTH = DM_WORD_W,
   parameter int  DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int PTR_W = AW + 1
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             wr_en_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             rd_en_i,
   output logic [WIDTH-1:0] rd_data_o,
   output logic [PTR_W-1:0] occ_o,
   output logic             full_o,
   output logic             empty_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wptr_q;
   logic [PTR_W-1:0] rptr_q;

   // Storage array; contents are don't-care until written, so no reset.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem_q[wptr_q[AW-1:0]] <= wr_data_i;
      end
   end

   // Write and read pointers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (wr_en_i) begin
            wptr_q <= wptr_q + PTR_W'(1);
         end
         if (rd_en_i) begin
            rptr_q <= rptr_q + PTR_W'(1);
         end
      end
   end

   assign occ_o     = wptr_q - rptr_q;
   assign full_o    = (occ_o == PTR_W'(DEPTH));
   assign empty_o   = (occ_o == '0);
   assign rd_data_o = mem_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/fifo_read_streamer.sv
// Read-side master for the non-FWFT DM word FIFO. Issues reads against a
// credit of free buffer slots, tracks reads in flight through a valid
// pipe matching the FIFO read latency, and presents the words as a
// valid/ready stream tagged with a per-frame word index and LAST.
module fifo_read_streamer
   import dm_fifo_pkg::*;
#(
   parameter int WIDTH      = DM_WORD_W,
   parameter int RD_LATENCY = 1,
   parameter int BUF_DEPTH  = 4,
   parameter int FRAME_LEN  = DM_FRAME_LEN
) (
   input  logic             RCLOCK,
   input  logic             RRESET_N,
   input  logic             ENABLE,
   input  logic             FIFO_EMPTY,
   output logic             FIFO_RE,
   input  logic [WIDTH-1:0] FIFO_Q,
   output logic [WIDTH-1:0] M_DATA,
   output logic             M_VALID,
   input  logic             M_READY,
   output logic             M_LAST,
   output logic [15:0]      WORD_CNT,
   output logic             BUSY
);

   localparam int          PTR_W    = $clog2(BUF_DEPTH) + 1;
   localparam int          CNT_W    = PTR_W + 2;
   localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);

   logic [RD_LATENCY-1:0] pipe_q;
   logic [RD_LATENCY-1:0] pipe_d;
   logic [15:0]           cnt_q;
   logic [15:0]           cnt_d;
   logic [CNT_W-1:0]      inflight;
   logic [PTR_W-1:0]      occ;
   logic                  credit_ok;
   logic                  buf_wr;
   logic                  buf_full;
   logic                  buf_empty;
   logic [WIDTH-1:0]      buf_data;
   logic                  xfer;

   // Count reads still travelling through the FIFO read latency.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
         inflight = inflight + CNT_W'(pipe_q[i]);
      end
   end

   // A read is only issued when its word is guaranteed a buffer slot, so
   // a stalled consumer can never cause a word to be dropped.
   assign credit_ok = (CNT_W'(occ) + inflight + CNT_W'(1)) <= CNT_W'(BUF_DEPTH);
   assign FIFO_RE   = RRESET_N & ENABLE & ~FIFO_EMPTY & credit_ok;

   // Shift the read-valid pipe; the tail stage lines up with FIFO_Q.
   always_comb begin
      pipe_d    = pipe_q << 1;
      pipe_d[0] = FIFO_RE;
   end

   // Read-valid pipe register.
   always_ff @(posedge RCLOCK) begin
      if (!RRESET_N) begin
         pipe_q <= '0;
      end else begin
         pipe_q <= pipe_d;
      end
   end

   assign buf_wr = pipe_q[RD_LATENCY-1];

   fifo_read_skid_buf #(
      .WIDTH (WIDTH),
      .DEPTH (BUF_DEPTH)
   ) u_buf (
      .clk_i     (RCLOCK),
      .rst_n_i   (RRESET_N),
      .wr_en_i   (buf_wr),
      .wr_data_i (FIFO_Q),
      .rd_en_i   (xfer),
      .rd_data_o (buf_data),
      .occ_o     (occ),
      .full_o    (buf_full),
      .empty_o   (buf_empty)
   );

   assign M_VALID  = ~buf_empty;
   assign M_DATA   = M_VALID ? buf_data : '0;
   assign xfer     = M_VALID & M_READY;
   assign M_LAST   = M_VALID & (cnt_q == LAST_IDX);
   assign WORD_CNT = cnt_q;
   assign BUSY     = M_VALID | (pipe_q != '0);

   // Frame index advances per transfer and wraps after the LAST word.
   always_comb begin
      cnt_d = cnt_q;
      if (xfer) begin
         cnt_d = M_LAST ? 16'd0 : cnt_q + 16'd1;
      end
   end

   // Frame index register.
   always_ff @(posedge RCLOCK) begin
      if (!RRESET_N) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // The credit rule makes overflow impossible; flag it if it ever happens.
   always_ff @(posedge RCLOCK) begin
      if (RRESET_N && buf_wr && !xfer) begin
         assert (!buf_full);
      end
   end

endmodule
